// File: rtl/pingpong_linebuf_pkg.sv
// pingpong_linebuf_pkg
// Shared definitions for the ping-pong line buffer:
//   bank_t           - one-bit bank index (bank 0 / bank 1)
//   addr_wid_ok()    - true when an ADDR_WID-bit address can reach every
//                      entry of a LEN-entry line; used as an elaboration check
package pingpong_linebuf_pkg;

  typedef logic bank_t;

  function automatic bit addr_wid_ok(input int len, input int addr_wid);
    return (longint'(1) << addr_wid) >= longint'(len);
  endfunction

endpackage

// File: rtl/pingpong_linebuf_ram.sv
// linebuf_ram
// Simple dual-port RAM holding both banks of the line buffer (2*LEN words).
// Bank 0 occupies entries [0, LEN), bank 1 occupies [LEN, 2*LEN).
// Ports:
//   clk      - clock, rising edge
//   reset_n  - synchronous active-low reset, clears only the read register
//   we       - write enable
//   wr_bank  - bank select for the write port
//   wr_addr  - word address within the write bank (must be < LEN)
//   wr_data  - write data
//   rd_bank  - bank select for the read port
//   rd_addr  - word address within the read bank
//   rd_zero  - force the registered read data to zero this cycle
//   rd_data  - registered read data (1 cycle latency)
module linebuf_ram
  import pingpong_linebuf_pkg::*;
#(
  parameter int LEN      = 320,
  parameter int WID      = 8,
  parameter int ADDR_WID = 9
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                we,
  input  bank_t               wr_bank,
  input  logic [ADDR_WID-1:0] wr_addr,
  input  logic [WID-1:0]      wr_data,
  input  bank_t               rd_bank,
  input  logic [ADDR_WID-1:0] rd_addr,
  input  logic                rd_zero,
  output logic [WID-1:0]      rd_data
);

  localparam int DEPTH = 2 * LEN;
  localparam int IDX_W = $clog2(DEPTH);

  logic [WID-1:0]   mem [DEPTH];
  logic [WID-1:0]   rd_data_q;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  // Bank 1 is offset by LEN rather than by a power of two so the array
  // holds exactly 2*LEN words.
  assign wr_idx = wr_bank ? IDX_W'(LEN) + IDX_W'(wr_addr) : IDX_W'(wr_addr);
  assign rd_idx = rd_bank ? IDX_W'(LEN) + IDX_W'(rd_addr) : IDX_W'(rd_addr);

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Output register carries the reset/zero so the array itself stays a
  // plain block RAM; an out-of-range address never touches the array.
  always_ff @(posedge clk) begin
    if (!reset_n || rd_zero) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_idx];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pingpong_linebuf.sv
// pingpong_linebuf
// Double-buffered line buffer: a writer fills one bank sequentially while a
// reader randomly accesses the other, completed bank. Banks swap on line
// completion (writer side) and on release (reader side).
// Ports:
//   clk        - clock, rising edge
//   reset_n    - synchronous active-low reset
//   wr_en      - write request
//   wr_data    - write data
//   wr_ready   - current write bank can accept data
//   flush      - discard the partially written line
//   rd_addr    - random read address into the read bank
//   rd_data    - registered read data (1 cycle latency, 0 when addr >= LEN)
//   rd_valid   - read bank holds a complete line
//   rd_release - reader is finished with the read bank
//   overflow   - sticky: a write was attempted while wr_ready was low
//   clr_ovf    - clears overflow (a simultaneous new overflow wins)
//   wr_level   - words written into the current write bank
module pingpong_linebuf
  import pingpong_linebuf_pkg::*;
#(
  parameter int LEN      = 320,
  parameter int WID      = 8,
  parameter int ADDR_WID = 9
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [WID-1:0]      wr_data,
  output logic                wr_ready,
  input  logic                flush,
  input  logic [ADDR_WID-1:0] rd_addr,
  output logic [WID-1:0]      rd_data,
  output logic                rd_valid,
  input  logic                rd_release,
  output logic                overflow,
  input  logic                clr_ovf,
  output logic [ADDR_WID-1:0] wr_level
);

  if (!addr_wid_ok(LEN, ADDR_WID)) begin : g_addr_check
    $error("pingpong_linebuf: ADDR_WID too small for LEN");
  end

  localparam logic [ADDR_WID-1:0] LAST_PTR = ADDR_WID'(LEN - 1);
  localparam logic [ADDR_WID:0]   LEN_EXT  = (ADDR_WID + 1)'(LEN);

  bank_t               wr_bank_q, wr_bank_d;
  bank_t               rd_bank_q, rd_bank_d;
  logic [ADDR_WID-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]          full_q, full_d;
  logic                overflow_q, overflow_d;

  logic wr_accept;
  logic line_done;
  logic release_ok;
  logic rd_oob;

  assign wr_ready = !full_q[wr_bank_q];
  assign rd_valid = full_q[rd_bank_q];
  assign wr_level = wr_ptr_q;
  assign overflow = overflow_q;

  assign wr_accept  = wr_en && wr_ready && !flush;
  assign line_done  = wr_accept && (wr_ptr_q == LAST_PTR);
  assign release_ok = rd_release && rd_valid;
  assign rd_oob     = {1'b0, rd_addr} >= LEN_EXT;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    wr_bank_d  = wr_bank_q;
    if (flush) begin
      wr_ptr_d = '0;
    end else if (line_done) begin
      wr_ptr_d  = '0;
      wr_bank_d = !wr_bank_q;
    end else if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    rd_bank_d  = rd_bank_q ^ release_ok;
    // Set dominates clear; flush suppresses the overflow event entirely.
    overflow_d = (wr_en && !wr_ready && !flush) || (overflow_q && !clr_ovf);
  end

  // Completion and release can coincide but always target different banks,
  // because the bank being written is never full.
  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    assign full_d[gi] = (full_q[gi] && !(release_ok && (rd_bank_q == bank_t'(gi))))
                      || (line_done && (wr_bank_q == bank_t'(gi)));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      full_q     <= 2'b00;
      overflow_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // Read uses the pre-toggle rd_bank_q, so a read issued with a release
  // still returns the line being released.
  linebuf_ram #(
    .LEN      (LEN),
    .WID      (WID),
    .ADDR_WID (ADDR_WID)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_accept),
    .wr_bank (wr_bank_q),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_bank (rd_bank_q),
    .rd_addr (rd_addr),
    .rd_zero (rd_oob),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_pingpong_linebuf.sv
// tb_pingpong_linebuf
// Directed self-checking bench for pingpong_linebuf (LEN=320, WID=8, ADDR_WID=9).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit after the following rising edge.
module tb_pingpong_linebuf;

  localparam int LEN      = 320;
  localparam int WID      = 8;
  localparam int ADDR_WID = 9;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                wr_en;
  logic [WID-1:0]      wr_data;
  logic                wr_ready;
  logic                flush;
  logic [ADDR_WID-1:0] rd_addr;
  logic [WID-1:0]      rd_data;
  logic                rd_valid;
  logic                rd_release;
  logic                overflow;
  logic                clr_ovf;
  logic [ADDR_WID-1:0] wr_level;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pingpong_linebuf #(
    .LEN      (LEN),
    .WID      (WID),
    .ADDR_WID (ADDR_WID)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .flush      (flush),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_release (rd_release),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .wr_level   (wr_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("pass %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writes n words (base+i) mod 256; optionally releases on the last word
  // while reading rel_addr in that same cycle.
  task automatic write_words(input int base, input int n, input bit rel_last, input int rel_addr);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = WID'((base + i) & 8'hff);
      if (rel_last && (i == n - 1)) begin
        rd_release = 1'b1;
        rd_addr    = ADDR_WID'(rel_addr);
      end
      tick();
    end
    wr_en      = 1'b0;
    rd_release = 1'b0;
  endtask

  task automatic read_at(input int addr, output logic [WID-1:0] val);
    rd_addr = ADDR_WID'(addr);
    tick();
    val = rd_data;
  endtask

  task automatic release_bank();
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WID-1:0] v;

    reset_n    = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    flush      = 1'b0;
    rd_addr    = '0;
    rd_release = 1'b0;
    clr_ovf    = 1'b0;
    tick();
    tick();
    check("reset_wr_ready", 32'(wr_ready), 32'd1);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_wr_level", 32'(wr_level), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_rd_data",  32'(rd_data),  32'd0);
    reset_n = 1'b1;
    tick();

    // Line A (0..319 mod 256) into bank 0.
    write_words(0, 10, 1'b0, 0);
    check("level_after_10", 32'(wr_level), 32'd10);
    write_words(10, LEN - 10, 1'b0, 0);
    check("a_rd_valid", 32'(rd_valid), 32'd1);
    check("a_wr_ready", 32'(wr_ready), 32'd1);
    check("a_wr_level", 32'(wr_level), 32'd0);
    read_at(5, v);
    check("a_read_5", 32'(v), 32'd5);
    read_at(300, v);
    check("a_read_300", 32'(v), 32'd44);

    // Line B (100+i) into bank 1: both banks full.
    write_words(100, LEN, 1'b0, 0);
    check("both_full_wr_ready", 32'(wr_ready), 32'd0);
    check("both_full_rd_valid", 32'(rd_valid), 32'd1);
    read_at(7, v);
    check("oldest_first_read_7", 32'(v), 32'd7);
    wr_en   = 1'b1;
    wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_level_held", 32'(wr_level), 32'd0);
    rd_addr = '0;
    release_bank();
    check("release_wr_ready", 32'(wr_ready), 32'd1);
    check("release_cycle_old_bank", 32'(rd_data), 32'd0);
    check("release_rd_valid", 32'(rd_valid), 32'd1);
    read_at(0, v);
    check("b_read_0", 32'(v), 32'd100);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Line C (200+i) into bank 0, releasing B on the last write while
    // reading B[10].
    write_words(200, LEN, 1'b1, 10);
    check("sim_rel_old_data", 32'(rd_data), 32'd110);
    check("sim_rel_rd_valid", 32'(rd_valid), 32'd1);
    check("sim_rel_wr_ready", 32'(wr_ready), 32'd1);
    check("sim_rel_wr_level", 32'(wr_level), 32'd0);
    read_at(10, v);
    check("c_read_10", 32'(v), 32'd210);

    // Partial line into bank 1, then flush together with a write.
    write_words(50, 100, 1'b0, 0);
    check("partial_level", 32'(wr_level), 32'd100);
    wr_en   = 1'b1;
    flush   = 1'b1;
    wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    flush = 1'b0;
    check("flush_level", 32'(wr_level), 32'd0);
    check("flush_no_ovf", 32'(overflow), 32'd0);
    write_words(30, LEN, 1'b0, 0);
    check("d_both_full", 32'(wr_ready), 32'd0);
    release_bank();
    read_at(0, v);
    check("d_read_0", 32'(v), 32'd30);
    read_at(99, v);
    check("d_read_99", 32'(v), 32'd129);
    read_at(319, v);
    check("d_read_319", 32'(v), 32'd93);
    read_at(320, v);
    check("oob_320", 32'(v), 32'd0);
    read_at(511, v);
    check("oob_511", 32'(v), 32'd0);

    // Release D: both banks empty; a further release must be ignored.
    release_bank();
    check("empty_rd_valid", 32'(rd_valid), 32'd0);
    release_bank();
    check("ign_rel_rd_valid", 32'(rd_valid), 32'd0);
    check("ign_rel_wr_ready", 32'(wr_ready), 32'd1);
    check("ign_rel_wr_level", 32'(wr_level), 32'd0);
    write_words(77, LEN, 1'b0, 0);
    check("e_rd_valid", 32'(rd_valid), 32'd1);
    read_at(0, v);
    check("e_read_0", 32'(v), 32'd77);

    // Line F fills the other bank; overflow with simultaneous clear.
    write_words(5, LEN, 1'b0, 0);
    check("f_both_full", 32'(wr_ready), 32'd0);
    wr_en   = 1'b1;
    clr_ovf = 1'b1;
    tick();
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);

    // Reset with both banks full and overflow set.
    read_at(3, v);
    check("pre_reset_read", 32'(v), 32'd80);
    reset_n = 1'b0;
    tick();
    check("rst_full_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_full_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_full_overflow", 32'(overflow), 32'd0);
    check("rst_full_rd_data",  32'(rd_data),  32'd0);
    reset_n = 1'b1;
    tick();

    // Reset mid-line discards the partial count.
    write_words(1, 5, 1'b0, 0);
    check("mid_level", 32'(wr_level), 32'd5);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_level", 32'(wr_level), 32'd0);
    check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
